// File: rtl/tanh_pkg.sv
// rtl/tanh_pkg.sv - Q5.26 constants, tanh knot/slope tables and FSM states
package tanh_pkg;

   localparam int XYZ_WIDTH = 32;
   localparam int FRAC      = 26;
   localparam int SEG_BITS  = 4;
   localparam int TBL_W     = 27;

   localparam logic [XYZ_WIDTH-1:0] ONE = 32'h0400_0000;

   // y[k] = round(tanh(0.25*k) * 2^26), k = 0..16
   localparam logic [TBL_W-1:0] KNOT_TBL [0:16] = '{
      27'd0,        27'd16436213, 27'd31012157, 27'd42624125,
      27'd51109719, 27'd56927351, 27'd60743471, 27'd63174643,
      27'd64694796, 27'd65634222, 27'd66210565, 27'd66562579,
      27'd66776994, 27'd66907379, 27'd66986585, 27'd67034671,
      27'd67063854
   };

   // s[k] = (y[k+1] - y[k]) * 4, so y[k] + (s[k]*t >> 26) interpolates a 0.25-wide segment
   localparam logic [TBL_W-1:0] SLOPE_TBL [0:15] = '{
      27'd65744852, 27'd58303776, 27'd46447872, 27'd33942376,
      27'd23270528, 27'd15264480, 27'd9724688,  27'd6080612,
      27'd3757704,  27'd2305372,  27'd1408056,  27'd857660,
      27'd521540,   27'd316824,   27'd192344,   27'd116732
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEG,
      ST_MUL,
      ST_ACC,
      ST_DONE,
      ST_RELEASE
   } state_t;

endpackage

// File: rtl/tanh_pwl_rom.sv
// rtl/tanh_pwl_rom.sv - segment index to knot/slope lookup, plus saturation endpoint
module tanh_pwl_rom
   import tanh_pkg::*;
(
   input  logic [SEG_BITS-1:0] idx,
   output logic [TBL_W-1:0]    knot,
   output logic [TBL_W-1:0]    slope,
   output logic [TBL_W-1:0]    y_sat
);

   assign knot  = KNOT_TBL[{1'b0, idx}];
   assign slope = SLOPE_TBL[idx];
   assign y_sat = KNOT_TBL[16];

endmodule

// File: rtl/tanh_pwl_responder.sv
// rtl/tanh_pwl_responder.sv - serial 16-segment PWL tanh on three Q5.26 operands
module tanh_pwl_responder
   import tanh_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 wa,
   input  logic [XYZ_WIDTH-1:0] ddx,
   input  logic [XYZ_WIDTH-1:0] ddy,
   input  logic [XYZ_WIDTH-1:0] ddz,
   output logic [XYZ_WIDTH-1:0] tanx,
   output logic [XYZ_WIDTH-1:0] tany,
   output logic [XYZ_WIDTH-1:0] tanz,
   output logic                 en
);

   localparam int T_W = FRAC - 2;

   state_t                 state_q, state_d;
   logic [XYZ_WIDTH-1:0]   op_x, op_y, op_z;
   logic [XYZ_WIDTH-1:0]   op_c, mag_c, res_c;
   logic [1:0]             ch;
   logic                   sign_r, sat_r, sat_c;
   logic [T_W-1:0]         t_r;
   logic [TBL_W-1:0]       knot_r, slope_r, knot_c, slope_c, y_sat;
   logic [T_W:0]           prod_r;
   logic [TBL_W+T_W-1:0]   prod_full;
   logic [TBL_W:0]         r_c;
   logic [SEG_BITS-1:0]    idx_c;

   tanh_pwl_rom u_rom (
      .idx   (idx_c),
      .knot  (knot_c),
      .slope (slope_c),
      .y_sat (y_sat)
   );

   // select the operand for the current channel and split it into segment and offset
   always_comb begin
      op_c = op_z;
      case (ch)
         2'd0:    op_c = op_x;
         2'd1:    op_c = op_y;
         default: op_c = op_z;
      endcase
      mag_c = op_c[XYZ_WIDTH-1] ? (~op_c + 32'd1) : op_c;
      // 0x8000_0000 negates to itself, which still compares above 4.0
      sat_c = (mag_c >= (ONE << 2));
      idx_c = mag_c[FRAC+1:FRAC-2];
   end

   // shared multiplier, accumulate and sign restore
   always_comb begin
      prod_full = {{T_W{1'b0}}, slope_r} * {{TBL_W{1'b0}}, t_r};
      r_c       = sat_r ? {1'b0, y_sat} : ({1'b0, knot_r} + {3'b000, prod_r});
      res_c     = {{(XYZ_WIDTH-TBL_W-1){1'b0}}, r_c};
      if (sign_r) begin
         res_c = ~res_c + 32'd1;
      end
   end

   // state register; clr forces IDLE ahead of everything else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else if (clr) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state: three SEG/MUL/ACC passes, then a single DONE, then wait for wa release
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (!wa) state_d = ST_SEG;
         ST_SEG:     state_d = ST_MUL;
         ST_MUL:     state_d = ST_ACC;
         ST_ACC:     state_d = (ch == 2'd2) ? ST_DONE : ST_SEG;
         ST_DONE:    state_d = ST_RELEASE;
         ST_RELEASE: if (wa) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // datapath registers, results and the registered completion strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_x <= '0; op_y <= '0; op_z <= '0; ch <= '0;
         sign_r <= 1'b0; sat_r <= 1'b0; t_r <= '0;
         knot_r <= '0; slope_r <= '0; prod_r <= '0;
         tanx <= '0; tany <= '0; tanz <= '0; en <= 1'b0;
      end else if (clr) begin
         ch <= '0;
         tanx <= '0; tany <= '0; tanz <= '0; en <= 1'b0;
      end else begin
         en <= (state_q == ST_DONE);
         case (state_q)
            ST_IDLE: begin
               if (!wa) begin
                  op_x <= ddx; op_y <= ddy; op_z <= ddz;
                  ch   <= 2'd0;
               end
            end
            ST_SEG: begin
               sign_r  <= op_c[XYZ_WIDTH-1];
               sat_r   <= sat_c;
               knot_r  <= knot_c;
               slope_r <= slope_c;
               t_r     <= mag_c[T_W-1:0];
            end
            ST_MUL: begin
               prod_r <= (T_W+1)'(prod_full >> FRAC);
            end
            ST_ACC: begin
               case (ch)
                  2'd0:    tanx <= res_c;
                  2'd1:    tany <= res_c;
                  default: tanz <= res_c;
               endcase
               if (ch != 2'd2) ch <= ch + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tanh_pwl_responder.sv
// tb/tb_tanh_pwl_responder.sv - scoreboard bench for tanh_pwl_responder
module tb_tanh_pwl_responder;

   logic        clk, rst, clr, wa, en;
   logic [31:0] ddx, ddy, ddz, tanx, tany, tanz;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int en_count = 0;

   typedef struct {
      logic [31:0] ex, ey, ez;
      int          c0;
      bit          sym;
   } exp_t;

   exp_t sb[$];

   tanh_pwl_responder dut (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .wa   (wa),
      .ddx  (ddx),
      .ddy  (ddy),
      .ddz  (ddz),
      .tanx (tanx),
      .tany (tany),
      .tanz (tanz),
      .en   (en)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint knot_ref(input int k);
      return longint'($rtoi($tanh(0.25 * k) * 67108864.0 + 0.5));
   endfunction

   // reference: linear interpolation of true tanh between quarter-unit knots, odd extension
   function automatic logic [31:0] model(input logic [31:0] v);
      longint sv, a, r, rem;
      int k;
      sv = longint'($signed(v));
      a  = (sv < 0) ? -sv : sv;
      if (a >= 64'sd268435456) begin
         r = knot_ref(16);
      end else begin
         k   = int'(a / 16777216);
         rem = a % 16777216;
         r   = knot_ref(k) + ((knot_ref(k + 1) - knot_ref(k)) * rem) / 16777216;
      end
      if (sv < 0) r = -r;
      return 32'(r);
   endfunction

   task automatic cmp_tol(input string nm, input int act, input int exp_v);
      int d;
      checks++;
      d = act - exp_v;
      if (d > 1 || d < -1) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (+/-1)", nm, act, exp_v);
      end
   endtask

   task automatic cmp_eq(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
      end
   endtask

   // monitor: every en pulse must match the oldest outstanding request
   always @(negedge clk) begin
      exp_t e;
      if (rst && en) begin
         en_count++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_en actual=1 expected=0 cycle=%0d", cyc);
         end else begin
            e = sb.pop_front();
            cmp_tol("tanx", $signed(tanx), $signed(e.ex));
            cmp_tol("tany", $signed(tany), $signed(e.ey));
            cmp_tol("tanz", $signed(tanz), $signed(e.ez));
            cmp_eq("latency", cyc - e.c0, 10);
            if (e.sym) cmp_eq("odd_sym", $signed(tany), -$signed(tanx));
         end
      end
   end

   task automatic do_txn(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input int hold);
      exp_t e;
      int   n0, waited;
      @(negedge clk);
      ddx = x; ddy = y; ddz = z; wa = 1'b0;
      e.ex = model(x); e.ey = model(y); e.ez = model(z);
      e.c0 = cyc + 1;
      e.sym = (y == -x) && (x != 32'h8000_0000);
      sb.push_back(e);
      n0 = en_count;
      waited = 0;
      while (en_count == n0 && waited < 40) begin
         @(negedge clk);
         #1;
         ddx = $urandom; ddy = $urandom; ddz = $urandom;
         waited++;
      end
      if (en_count == n0) begin
         checks++;
         failures++;
         $display("FAIL en_timeout actual=no_en expected=en_within_40");
         sb.delete();
      end
      repeat (hold) @(negedge clk);
      wa = 1'b1;
   endtask

   function automatic logic [31:0] rnd_op();
      logic [31:0] m;
      case ($urandom_range(0, 3))
         0:       m = $urandom_range(0, 32'h0400_0000);
         1:       m = $urandom_range(0, 32'h1200_0000);
         2:       m = 32'($urandom_range(0, 17)) << 24;
         default: m = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) m = -m;
      return m;
   endfunction

   initial begin
      logic [31:0] r;
      int n;
      rst = 1'b0; clr = 1'b0; wa = 1'b1;
      ddx = '0; ddy = '0; ddz = '0;
      repeat (3) @(negedge clk);
      cmp_eq("reset_tanx", $signed(tanx), 0);
      cmp_eq("reset_tany", $signed(tany), 0);
      cmp_eq("reset_tanz", $signed(tanz), 0);
      cmp_eq("reset_en", int'(en), 0);
      rst = 1'b1;
      @(negedge clk);

      do_txn(32'h0000_0000, 32'h0400_0000, 32'hFC00_0000, 0);
      do_txn(32'h0080_0000, 32'hFF80_0000, 32'h0100_0000, 1);
      do_txn(32'h1400_0000, 32'h8000_0000, 32'h1000_0000, 0);
      do_txn(32'h0FFF_FFFF, 32'hF000_0001, 32'hF000_0000, 2);

      n = en_count;
      do_txn(32'h0200_0000, 32'hFE00_0000, 32'h0C00_0000, 30);
      cmp_eq("single_en_hold", en_count - n, 1);
      do_txn(32'h0300_0000, 32'hFD00_0000, 32'h07FF_FFFF, 0);

      // clr lands on E5: tanx already written, nothing may complete afterwards
      @(negedge clk);
      ddx = 32'h0400_0000; ddy = 32'h0400_0000; ddz = 32'h0400_0000; wa = 1'b0;
      repeat (4) @(negedge clk);
      cmp_tol("pre_clr_tanx", $signed(tanx), 51109719);
      @(negedge clk);
      clr = 1'b1; wa = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      cmp_eq("clr_tanx", $signed(tanx), 0);
      cmp_eq("clr_tany", $signed(tany), 0);
      cmp_eq("clr_tanz", $signed(tanz), 0);
      cmp_eq("clr_en", int'(en), 0);
      n = en_count;
      repeat (15) @(negedge clk);
      cmp_eq("clr_no_en", en_count - n, 0);
      do_txn(32'h0600_0000, 32'hFA00_0000, 32'h0000_0001, 0);

      // asynchronous reset while channel y is in MUL
      @(negedge clk);
      ddx = 32'h0400_0000; ddy = 32'h0200_0000; ddz = 32'h0100_0000; wa = 1'b0;
      repeat (4) @(negedge clk);
      cmp_tol("pre_rst_tanx", $signed(tanx), 51109719);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      cmp_eq("rst_tanx", $signed(tanx), 0);
      cmp_eq("rst_tany", $signed(tany), 0);
      cmp_eq("rst_tanz", $signed(tanz), 0);
      cmp_eq("rst_en", int'(en), 0);
      @(negedge clk);
      rst = 1'b1; wa = 1'b1;
      @(negedge clk);
      do_txn(32'h0400_0000, 32'hFC00_0000, 32'h0080_0000, 0);

      for (int i = 0; i < 24; i++) begin
         r = rnd_op();
         if (i % 2 == 0) do_txn(r, -r, rnd_op(), $urandom_range(0, 3));
         else            do_txn(rnd_op(), rnd_op(), r, $urandom_range(0, 3));
      end

      repeat (5) @(negedge clk);
      cmp_eq("pending_expected", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
